// File: rtl/led_pkg.sv
// Shared constants and types for the flow-LED chain: the board clock rate,
// the 1 ms tick divisor and the default brightness resolution.
`timescale 1ns/1ps
package led_pkg;
   localparam int CLK_HZ             = 25_000_000;
   localparam int TICK_1MS           = CLK_HZ / 1000;
   localparam int PWM_BITS_DEFAULT   = 8;
   localparam int DECAY_STEP_DEFAULT = 16;

   typedef logic [PWM_BITS_DEFAULT-1:0] level_t;
endpackage

// File: rtl/led_pwm_channel.sv
// One comet-trail channel: a brightness level that snaps to full when the
// pattern bit is set, decays linearly on each tick, and drives a PWM compare.
`timescale 1ns/1ps
module led_pwm_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS   = PWM_BITS_DEFAULT,
   parameter int DECAY_STEP = DECAY_STEP_DEFAULT
) (
   input  logic                clk_25mhz,
   input  logic                rst,
   input  logic                enable,
   input  logic                tick,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                led_in,
   output logic                led_out
);

   localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
   localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);

   logic [PWM_BITS-1:0] level;

   // A set pattern bit beats a simultaneous tick; decay saturates at zero.
   always_ff @(posedge clk_25mhz) begin
      if (rst) begin
         level   <= '0;
         led_out <= 1'b0;
      end else begin
         if (led_in) begin
            level <= LEVEL_MAX;
         end else if (tick) begin
            level <= (level > STEP) ? (level - STEP) : '0;
         end
         led_out <= enable & (level > pwm_cnt);
      end
   end

endmodule

// File: rtl/led_trail_pwm.sv
// Turns the hard on/off flow-LED pattern into a fading comet trail. The decay
// prescaler and the PWM counter are shared by every channel.
`timescale 1ns/1ps
module led_trail_pwm
   import led_pkg::*;
#(
   parameter int N_LED      = 4,
   parameter int PWM_BITS   = PWM_BITS_DEFAULT,
   parameter int TICK_DIV   = TICK_1MS,
   parameter int DECAY_STEP = DECAY_STEP_DEFAULT
) (
   input  logic             clk_25mhz,
   input  logic             rst,
   input  logic             enable,
   input  logic [N_LED-1:0] led_in,
   output logic [N_LED-1:0] led_out,
   output logic             tick
);

   localparam int              PRESC_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   logic [PRESC_W-1:0]  presc;
   logic [PWM_BITS-1:0] pwm_cnt;

   // tick is registered, so it is high the cycle after the prescaler shows its last count.
   always_ff @(posedge clk_25mhz) begin
      if (rst) begin
         presc   <= '0;
         tick    <= 1'b0;
         pwm_cnt <= '0;
      end else begin
         presc   <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
         tick    <= (presc == PRESC_LAST);
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < N_LED; i++) begin : g_chan
      led_pwm_channel #(
         .PWM_BITS   (PWM_BITS),
         .DECAY_STEP (DECAY_STEP)
      ) u_chan (
         .clk_25mhz (clk_25mhz),
         .rst       (rst),
         .enable    (enable),
         .tick      (tick),
         .pwm_cnt   (pwm_cnt),
         .led_in    (led_in[i]),
         .led_out   (led_out[i])
      );
   end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm with a 10-cycle tick: directed scenarios plus a
// randomized pattern phase, all compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_led_trail_pwm;

   localparam int N_LED = 4;
   localparam int TD    = 10;
   localparam int STEP  = 16;
   localparam int LMAX  = 255;

   logic             clk_25mhz = 1'b0;
   logic             rst       = 1'b1;
   logic             enable    = 1'b0;
   logic [N_LED-1:0] led_in    = '0;
   logic [N_LED-1:0] led_out;
   logic             tick;

   int vectors     = 0;
   int miscompares = 0;

   int               edges_since_reset;
   int               lvl [N_LED];
   logic [N_LED-1:0] exp_out;
   logic             exp_tick;

   always #20 clk_25mhz = ~clk_25mhz;

   led_trail_pwm #(
      .N_LED      (N_LED),
      .PWM_BITS   (8),
      .TICK_DIV   (TD),
      .DECAY_STEP (STEP)
   ) dut (
      .clk_25mhz (clk_25mhz),
      .rst       (rst),
      .enable    (enable),
      .led_in    (led_in),
      .led_out   (led_out),
      .tick      (tick)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: time since reset gives tick and PWM phase; levels follow the fade rules.
   task automatic applyStimulus();
      int   phase;
      logic tick_before;
      @(posedge clk_25mhz);
      if (rst) begin
         edges_since_reset = 0;
         exp_tick          = 1'b0;
         exp_out           = '0;
         foreach (lvl[i]) lvl[i] = 0;
      end else begin
         phase       = edges_since_reset % 256;
         tick_before = exp_tick;
         for (int i = 0; i < N_LED; i++) exp_out[i] = enable && (lvl[i] > phase);
         for (int i = 0; i < N_LED; i++) begin
            if (led_in[i]) lvl[i] = LMAX;
            else if (tick_before) lvl[i] = (lvl[i] - STEP < 0) ? 0 : lvl[i] - STEP;
         end
         exp_tick = ((edges_since_reset % TD) == TD - 1);
         edges_since_reset++;
      end
      #1;
      checkOutput("led_out", 32'(led_out), 32'(exp_out));
      checkOutput("tick", 32'(tick), 32'(exp_tick));
   endtask

   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus();
   endtask

   task automatic waitTick(input string tag);
      int budget;
      budget = 3 * TD;
      applyStimulus();
      while (tick !== 1'b1 && budget > 0) begin
         applyStimulus();
         budget--;
      end
      checkOutput(tag, 32'(tick), 32'd1);
   endtask

   initial begin
      int highs;
      int others;
      int ticks_seen;
      int budget;
      int hold;

      // Reset held with all pattern bits set
      rst    = 1'b1;
      enable = 1'b1;
      led_in = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         applyStimulus();
         checkOutput("reset_led_out", 32'(led_out), 32'd0);
         checkOutput("reset_tick", 32'(tick), 32'd0);
      end
      rst = 1'b0;
      applyStimulus();
      checkOutput("release_plus1", 32'(led_out), 32'h0);
      applyStimulus();
      checkOutput("release_plus2", 32'(led_out), 32'hF);

      // Let everything fade, then measure full-on duty on channel 0
      led_in = 4'b0000;
      runCycles(20 * TD);
      led_in = 4'b0001;
      runCycles(2);
      highs  = 0;
      others = 0;
      for (int k = 0; k < 256; k++) begin
         applyStimulus();
         highs  += int'(led_out[0]);
         others += int'(|led_out[3:1]);
      end
      checkOutput("full_on_duty", 32'(highs), 32'd255);
      checkOutput("full_on_others", 32'(others), 32'd0);

      // Decay timing: release channel 0 just after a tick
      waitTick("decay_sync");
      applyStimulus();
      led_in     = 4'b0000;
      ticks_seen = 0;
      budget     = 16 * TD + 20;
      while (ticks_seen < 16 && budget > 0) begin
         applyStimulus();
         ticks_seen += int'(tick === 1'b1);
         budget--;
      end
      checkOutput("decay_16_ticks", 32'(ticks_seen), 32'd16);
      applyStimulus();
      highs = 0;
      for (int k = 0; k < 40; k++) begin
         applyStimulus();
         highs += int'(led_out[0]);
      end
      checkOutput("decay_dark", 32'(highs), 32'd0);

      // Collision: pattern bit and tick land on the same edge mid-fade
      led_in = 4'b0100;
      runCycles(2);
      led_in = 4'b0000;
      for (int t = 0; t < 8; t++) waitTick("collision_fade");
      led_in = 4'b0100;
      applyStimulus();
      led_in = 4'b0000;
      runCycles(3 * TD);

      // Enable gating while the pattern shifts
      led_in = 4'b0001;
      runCycles(2);
      enable = 1'b0;
      highs  = 0;
      for (int k = 0; k < 300; k++) begin
         if (k == 250) led_in = 4'b0010;
         applyStimulus();
         highs += int'(|led_out);
      end
      checkOutput("gated_off", 32'(highs), 32'd0);
      enable = 1'b1;
      runCycles(300);

      // Randomized pattern, enable and an occasional reset
      hold = 0;
      for (int k = 0; k < 3000; k++) begin
         if (hold == 0) begin
            led_in = N_LED'($urandom);
            hold   = $urandom_range(1, 60);
         end
         hold--;
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         rst = ($urandom_range(0, 999) == 0);
         applyStimulus();
      end
      rst = 1'b0;
      runCycles(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/led_trail_pwm.md
Name: led_trail_pwm

Overview:
- Downstream stage of the 4-bit flow-LED pattern generator; sits between the shifting LED pattern and the board LED pins.
- Converts the hard on/off pattern into a "comet trail":
  - An LED whose pattern bit is set lights at full brightness.
  - When the bit clears, the LED fades out linearly through PWM, one decay step per millisecond.
- Runs entirely on the 25 MHz board clock; the pattern input is already synchronous to it.

Parameters:
- N_LED, 4, number of LED channels.
- PWM_BITS, 8, width of the PWM counter and each brightness level; PWM period = 2^PWM_BITS cycles.
- TICK_DIV, 25000, clk_25mhz cycles per decay tick (1 ms at 25 MHz); must be >= 2.
- DECAY_STEP, 16, brightness decrement applied per tick; must be 1..2^PWM_BITS-1.

Ports:
- clk_25mhz  input  1  source clock, 25 MHz; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = drive LEDs, 0 = force all outputs off. Levels keep tracking while low.
- led_in  input  N_LED  pattern from the flow-LED stage; bit i = channel i on.
- led_out  output  N_LED  registered PWM drive to the LED pins, active-high.
- tick  output  1  one-cycle decay strobe; exported for debug and bench synchronisation.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Prescaler, pwm_cnt and all level[i] are cleared to 0.
  - led_out is cleared to 0 and tick is cleared to 0.
  - Reset asserted mid-fade discards all fade state.
  - First cycle after rst deasserts: counting resumes from 0.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick is registered and equals 1 for exactly the one cycle after the prescaler holds TICK_DIV-1.
  - One tick every TICK_DIV cycles.
- PWM counter:
  - pwm_cnt is a free-running PWM_BITS-wide counter incremented every cycle.
  - Wraps from 2^PWM_BITS-1 to 0.
  - Not affected by enable.
- Level update, per channel, evaluated each cycle in priority order:
  1. led_in[i]=1: level[i] <= 2^PWM_BITS-1 (max). This wins over a simultaneous tick.
  2. Else if tick=1:
     - If level[i] > DECAY_STEP: level[i] <= level[i] - DECAY_STEP.
     - Else: level[i] <= 0. Saturating; no underflow wrap.
  3. Else: level[i] holds.
- Output:
  - led_out[i] <= enable & (level[i] > pwm_cnt).
  - Level 0 gives a constant 0. Max level gives (2^PWM_BITS-1)/2^PWM_BITS duty, i.e. off only when pwm_cnt = max.
  - enable low forces led_out = 0 from the next edge.
- Latency:
  - led_in[i] rising at edge N: level[i] = max after edge N+1.
  - led_out[i]=1 after edge N+2, unless pwm_cnt = max at that compare; in that case it goes high one cycle later.
- Fade length with defaults: 255 steps 239, 223, ... 15, then 0, which is 16 ticks = 16 ms to dark after led_in[i] falls.
- Multiple channels are independent. Any combination of led_in bits, including all-ones or all-zeros, is legal.

Decomposition:
- Shared package led_pkg:
  - CLK_HZ = 25_000_000.
  - TICK_1MS = CLK_HZ/1000.
  - Default PWM_BITS and DECAY_STEP.
  - Typedef level_t (PWM_BITS-wide unsigned).
  - The flow-LED generator uses TICK_1MS from this package as well.
- Sub-module led_pwm_channel holds one channel's level register, the saturating decay and the compare.
  - Inputs: clk_25mhz, rst, enable, tick, pwm_cnt, led_in bit.
  - Output: one led_out bit.
  - Instantiated N_LED times by generate.
- Prescaler and pwm_cnt live in the top module and are shared by all channels.

Test Plan (bench uses TICK_DIV=10, defaults otherwise):
- Reset check: hold rst 3 cycles with led_in=4'b1111.
  - During reset: led_out=0 and tick=0.
  - After release: led_out[0..3] first go high 2 cycles after release.
- Full-on duty: led_in=4'b0001 steady, enable=1, measure over 256 cycles.
  - led_out[0] high for exactly 255 of 256 cycles.
  - led_out[3:1] = 0 throughout.
- Decay timing: drop led_in[0] 1→0 just after a tick.
  - Level sequence 255, 239, ..., 15, 0 on successive ticks.
  - led_out[0] constant 0 from the 16th tick onward.
  - High-cycle counts per 256-cycle window decrease monotonically.
- Collision: assert led_in[2]=1 in the same cycle tick=1 while level[2]=100.
  - level[2] becomes 255, not 84.
- Saturation: with level = 10, apply one tick and no led_in.
  - Level becomes 0, never wraps to 250.
- Enable gating: enable=0 for 300 cycles while the pattern shifts 0001→0010.
  - led_out=0 throughout.
  - On enable=1 the levels reflect the tracked fade: channel 0 partially decayed, channel 1 at 255.
